// File: rtl/icon_pkg.sv
// Shared definitions for the interconnect egress path: the default beat
// geometry, the packed beat type and the pointer-width helper.
package icon_pkg;

   localparam int ICON_ADDR_W = 9;
   localparam int ICON_DATA_W = 1;

   // One network beat at the default geometry: address in the upper bits, data below.
   typedef struct packed {
      logic [ICON_ADDR_W-1:0] addr;
      logic [ICON_DATA_W-1:0] data;
   } icon_beat_t;

   // Bits needed to index n entries, never less than one so a 1-entry
   // structure still gets a legal vector.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) begin
         w = w + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/icon_egress_fifo.sv
// Single-lane show-ahead FIFO for the egress buffer. The network cannot be
// stalled, so a beat that finds the FIFO full (and no pop this cycle) is
// discarded and recorded in a sticky overflow flag and a saturating counter.
module icon_egress_fifo
   import icon_pkg::*;
#(
   parameter int DATA_W = 1,
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_push,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_ready,
   input  logic              i_ovf_clr,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_ovf,
   output logic [CNT_W-1:0]  o_drop_cnt
);

   localparam int PTR_W  = clog2_min1(DEPTH);
   localparam int BEAT_W = ADDR_W + DATA_W;

   localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0] DROP_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] DROP_ONE   = CNT_W'(1);

   logic [BEAT_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             ovf_reg;
   logic [CNT_W-1:0] drop_cnt_reg;

   logic              is_empty;
   logic              is_full;
   logic              pop;
   logic              push_ok;
   logic              drop;
   logic [BEAT_W-1:0] head;

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == COUNT_FULL);
   // i_ready on an empty lane is not a handshake.
   assign pop      = !is_empty && i_ready;
   // A full lane still takes the beat when the head leaves in the same cycle.
   assign push_ok  = i_push && (!is_full || pop);
   assign drop     = i_push && is_full && !pop;

   // Storage write; no reset so the array maps onto RAM resources.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= {i_addr, i_data};
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push+pop leaves count alone.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + COUNT_ONE;
            2'b01:   count_reg <= count_reg - COUNT_ONE;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Overflow flag and saturating drop counter; a clear beats a same-cycle drop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ovf_reg      <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (i_ovf_clr) begin
         ovf_reg      <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (drop) begin
         ovf_reg <= 1'b1;
         if (drop_cnt_reg != DROP_MAX) begin
            drop_cnt_reg <= drop_cnt_reg + DROP_ONE;
         end
      end
   end

   // Show-ahead head: read straight from storage, forced to zero while empty
   // so the outputs are defined from reset onwards.
   assign head       = mem[rd_ptr_reg];
   assign o_valid    = !is_empty;
   assign o_addr     = is_empty ? '0 : head[BEAT_W-1:DATA_W];
   assign o_data     = is_empty ? '0 : head[DATA_W-1:0];
   assign o_full     = is_full;
   assign o_ovf      = ovf_reg;
   assign o_drop_cnt = drop_cnt_reg;

endmodule

// File: rtl/icon_egress_buf.sv
// Egress buffer behind the last interconnect stage: an optional capture
// register on the network outputs followed by one independent FIFO per lane
// presenting beats to the heap bank port with valid/ready.
module icon_egress_buf
   import icon_pkg::*;
#(
   parameter int INPUTS   = 32,
   parameter int DATA_W   = ICON_DATA_W,
   parameter int ADDR_W   = ICON_ADDR_W,
   parameter int DEPTH    = 4,
   parameter int PIPELINE = 1,
   parameter int CNT_W    = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [INPUTS-1:0]        i_valid,
   input  logic [INPUTS*ADDR_W-1:0] i_addr,
   input  logic [INPUTS*DATA_W-1:0] i_data,
   output logic [INPUTS-1:0]        o_valid,
   output logic [INPUTS*ADDR_W-1:0] o_addr,
   output logic [INPUTS*DATA_W-1:0] o_data,
   input  logic [INPUTS-1:0]        i_ready,
   output logic [INPUTS-1:0]        o_full,
   output logic [INPUTS-1:0]        o_ovf,
   input  logic [INPUTS-1:0]        i_ovf_clr,
   output logic [INPUTS*CNT_W-1:0]  o_drop_cnt
);

   logic [INPUTS-1:0]        wr_valid;
   logic [INPUTS*ADDR_W-1:0] wr_addr;
   logic [INPUTS*DATA_W-1:0] wr_data;

   generate
      if (PIPELINE != 0) begin : g_cap
         logic [INPUTS-1:0]        cap_valid_reg;
         logic [INPUTS*ADDR_W-1:0] cap_addr_reg;
         logic [INPUTS*DATA_W-1:0] cap_data_reg;

         // Retime the network outputs every cycle; the FIFO sees them one edge later.
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               cap_valid_reg <= '0;
               cap_addr_reg  <= '0;
               cap_data_reg  <= '0;
            end else begin
               cap_valid_reg <= i_valid;
               cap_addr_reg  <= i_addr;
               cap_data_reg  <= i_data;
            end
         end

         assign wr_valid = cap_valid_reg;
         assign wr_addr  = cap_addr_reg;
         assign wr_data  = cap_data_reg;
      end else begin : g_direct
         assign wr_valid = i_valid;
         assign wr_addr  = i_addr;
         assign wr_data  = i_data;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < INPUTS; gi++) begin : g_lane
         icon_egress_fifo #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W)
         ) u_fifo (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_push     (wr_valid[gi]),
            .i_addr     (wr_addr[gi*ADDR_W +: ADDR_W]),
            .i_data     (wr_data[gi*DATA_W +: DATA_W]),
            .i_ready    (i_ready[gi]),
            .i_ovf_clr  (i_ovf_clr[gi]),
            .o_valid    (o_valid[gi]),
            .o_addr     (o_addr[gi*ADDR_W +: ADDR_W]),
            .o_data     (o_data[gi*DATA_W +: DATA_W]),
            .o_full     (o_full[gi]),
            .o_ovf      (o_ovf[gi]),
            .o_drop_cnt (o_drop_cnt[gi*CNT_W +: CNT_W])
         );
      end
   endgenerate

endmodule

// File: tb/tb_icon_egress_buf.sv
// Bench for icon_egress_buf. Two instances share the network stimulus:
// index 0 writes directly (8-bit drop counter), index 1 has the capture
// register and a 2-bit drop counter. A queue-based model predicts every lane
// of both instances and is compared on every falling edge; directed literal
// checks pin the model at the interesting points.
module tb_icon_egress_buf;
   import icon_pkg::*;

   localparam int INPUTS = 32;
   localparam int ADDR_W = ICON_ADDR_W;
   localparam int DATA_W = ICON_DATA_W;
   localparam int DEPTH  = 4;
   localparam int CW0    = 8;
   localparam int CW1    = 2;

   logic clk;
   logic rst;
   logic [INPUTS-1:0]        valid;
   logic [INPUTS*ADDR_W-1:0] addr;
   logic [INPUTS*DATA_W-1:0] data;
   logic [INPUTS-1:0]        clr;
   logic [INPUTS-1:0]        rdy [2];

   logic [INPUTS-1:0]        ov [2];
   logic [INPUTS*ADDR_W-1:0] oa [2];
   logic [INPUTS*DATA_W-1:0] od [2];
   logic [INPUTS-1:0]        of [2];
   logic [INPUTS-1:0]        oo [2];
   logic [INPUTS*CW0-1:0]    oc0;
   logic [INPUTS*CW1-1:0]    oc1;

   int n_tests = 0;
   int n_fail  = 0;

   icon_egress_buf #(
      .INPUTS(INPUTS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .DEPTH(DEPTH), .PIPELINE(0), .CNT_W(CW0)
   ) u_p0 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_addr(addr), .i_data(data),
      .o_valid(ov[0]), .o_addr(oa[0]), .o_data(od[0]), .i_ready(rdy[0]),
      .o_full(of[0]), .o_ovf(oo[0]), .i_ovf_clr(clr), .o_drop_cnt(oc0)
   );

   icon_egress_buf #(
      .INPUTS(INPUTS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
      .DEPTH(DEPTH), .PIPELINE(1), .CNT_W(CW1)
   ) u_p1 (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_addr(addr), .i_data(data),
      .o_valid(ov[1]), .o_addr(oa[1]), .o_data(od[1]), .i_ready(rdy[1]),
      .o_full(of[1]), .o_ovf(oo[1]), .i_ovf_clr(clr), .o_drop_cnt(oc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   icon_beat_t mq [2][INPUTS][$];
   bit         m_ovf [2][INPUTS];
   int         m_cnt [2][INPUTS];
   bit         m_cap_v [INPUTS];
   icon_beat_t m_cap_b [INPUTS];
   int         cnt_max [2];

   initial begin
      cnt_max[0] = (1 << CW0) - 1;
      cnt_max[1] = (1 << CW1) - 1;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < INPUTS; l++) begin
               mq[d][l].delete();
               m_ovf[d][l] = 1'b0;
               m_cnt[d][l] = 0;
            end
         end
         for (int l = 0; l < INPUTS; l++) begin
            m_cap_v[l] = 1'b0;
            m_cap_b[l] = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            for (int l = 0; l < INPUTS; l++) begin
               bit         req;
               icon_beat_t b;
               if (d == 1) begin
                  req = m_cap_v[l];
                  b   = m_cap_b[l];
               end else begin
                  req    = valid[l];
                  b.addr = addr[l*ADDR_W +: ADDR_W];
                  b.data = data[l*DATA_W +: DATA_W];
               end
               if (mq[d][l].size() != 0 && rdy[d][l]) begin
                  void'(mq[d][l].pop_front());
               end
               if (req) begin
                  if (mq[d][l].size() < DEPTH) begin
                     mq[d][l].push_back(b);
                  end else begin
                     m_ovf[d][l] = 1'b1;
                     if (m_cnt[d][l] < cnt_max[d]) m_cnt[d][l]++;
                  end
               end
               if (clr[l]) begin
                  m_ovf[d][l] = 1'b0;
                  m_cnt[d][l] = 0;
               end
            end
         end
         for (int l = 0; l < INPUTS; l++) begin
            m_cap_v[l]      = valid[l];
            m_cap_b[l].addr = addr[l*ADDR_W +: ADDR_W];
            m_cap_b[l].data = data[l*DATA_W +: DATA_W];
         end
      end
   end

   // ---------------- checking helpers ----------------
   function automatic logic [31:0] get_cnt(input int d, input int l);
      if (d == 0) return 32'(oc0[l*CW0 +: CW0]);
      return 32'(oc1[l*CW1 +: CW1]);
   endfunction

   function automatic logic [31:0] get_addr(input int d, input int l);
      return 32'(oa[d][l*ADDR_W +: ADDR_W]);
   endfunction

   task automatic chk(input string nm, input int d, input int l,
                      input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d lane%0d: got 0x%0h expected 0x%0h @%0t",
                  nm, d, l, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every lane of both instances against the model.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int l = 0; l < INPUTS; l++) begin
            bit ev;
            ev = (mq[d][l].size() != 0);
            chk("cyc_valid", d, l, 32'(ov[d][l]), 32'(ev));
            chk("cyc_full",  d, l, 32'(of[d][l]), 32'(mq[d][l].size() == DEPTH));
            chk("cyc_ovf",   d, l, 32'(oo[d][l]), 32'(m_ovf[d][l]));
            chk("cyc_drop",  d, l, get_cnt(d, l), 32'(m_cnt[d][l]));
            if (ev) begin
               chk("cyc_addr", d, l, get_addr(d, l), 32'(mq[d][l][0].addr));
               chk("cyc_data", d, l, 32'(od[d][l]), 32'(mq[d][l][0].data));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_beat(input int l, input int a, input bit dv);
      valid[l] = 1'b1;
      addr[l*ADDR_W +: ADDR_W] = ADDR_W'(a);
      data[l*DATA_W +: DATA_W] = DATA_W'(dv);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst    = 1'b1;
      valid  = '0;
      addr   = '0;
      data   = '0;
      clr    = '0;
      rdy[0] = '1;
      rdy[1] = '1;
      tick(2);
      for (int d = 0; d < 2; d++) begin
         chk("rst_valid", d, 0, 32'(ov[d]), 32'h0);
         chk("rst_full",  d, 0, 32'(of[d]), 32'h0);
         chk("rst_ovf",   d, 0, 32'(oo[d]), 32'h0);
         chk("rst_addr5", d, 5, get_addr(d, 5), 32'h0);
      end
      chk("rst_drop0", 0, 0, 32'(oc0 != '0), 32'h0);
      chk("rst_drop1", 1, 0, 32'(oc1 != '0), 32'h0);
      rst = 1'b0;
      tick(1);

      // Single beat on lane 5, consumer always ready.
      set_beat(5, 'h1A3, 1'b1);
      tick(1);
      valid = '0;
      chk("t1_valid_e1", 0, 5, 32'(ov[0]), 32'h20);
      chk("t1_addr_e1",  0, 5, get_addr(0, 5), 32'h1A3);
      chk("t1_data_e1",  0, 5, 32'(od[0][5]), 32'h1);
      chk("t1_p1_early", 1, 5, 32'(ov[1]), 32'h0);
      tick(1);
      chk("t1_valid_e2", 1, 5, 32'(ov[1]), 32'h20);
      chk("t1_addr_e2",  1, 5, get_addr(1, 5), 32'h1A3);
      chk("t1_p0_popped", 0, 5, 32'(ov[0]), 32'h0);
      tick(1);
      chk("t1_p1_popped", 1, 5, 32'(ov[1]), 32'h0);

      // Fill and overflow lane 0 with the consumer stalled.
      rdy[0][0] = 1'b0;
      rdy[1][0] = 1'b0;
      for (int i = 0; i < 6; i++) begin
         set_beat(0, i, 1'(i));
         tick(1);
      end
      valid = '0;
      tick(2);
      for (int d = 0; d < 2; d++) begin
         chk("t2_full", d, 0, 32'(of[d][0]), 32'h1);
         chk("t2_ovf",  d, 0, 32'(oo[d][0]), 32'h1);
         chk("t2_drop", d, 0, get_cnt(d, 0), 32'd2);
         chk("t2_head", d, 0, get_addr(d, 0), 32'd0);
      end
      rdy[0][0] = 1'b1;
      rdy[1][0] = 1'b1;
      tick(1);
      chk("t2_head_after_pop", 0, 0, get_addr(0, 0), 32'd1);
      tick(5);

      // Drop counter saturation on lane 1, then a clear coinciding with a drop.
      rdy[0][1] = 1'b0;
      rdy[1][1] = 1'b0;
      for (int i = 0; i < 9; i++) begin
         set_beat(1, 16 + i, 1'b0);
         tick(1);
      end
      valid = '0;
      tick(2);
      chk("t3_sat_p1", 1, 1, get_cnt(1, 1), 32'd3);
      chk("t3_cnt_p0", 0, 1, get_cnt(0, 1), 32'd5);
      chk("t3_ovf_p1", 1, 1, 32'(oo[1][1]), 32'h1);
      set_beat(1, 30, 1'b1);
      tick(1);
      clr[1] = 1'b1;
      tick(1);
      valid = '0;
      clr   = '0;
      chk("t3_clr_ovf_p0", 0, 1, 32'(oo[0][1]), 32'h0);
      chk("t3_clr_cnt_p0", 0, 1, get_cnt(0, 1), 32'd0);
      chk("t3_clr_ovf_p1", 1, 1, 32'(oo[1][1]), 32'h0);
      chk("t3_clr_cnt_p1", 1, 1, get_cnt(1, 1), 32'd0);
      tick(1);
      chk("t3_late_drop_p1", 1, 1, get_cnt(1, 1), 32'd1);
      chk("t3_no_drop_p0",   0, 1, get_cnt(0, 1), 32'd0);
      rdy[0][1] = 1'b1;
      rdy[1][1] = 1'b1;
      clr[1]    = 1'b1;
      tick(1);
      clr = '0;
      tick(5);

      // Full lane 3 accepts a beat when it pops in the same cycle.
      rdy[0][3] = 1'b0;
      rdy[1][3] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_beat(3, i, 1'b0);
         tick(1);
      end
      valid = '0;
      tick(2);
      chk("t4_full_before", 1, 3, 32'(of[1][3]), 32'h1);
      set_beat(3, 9, 1'b1);
      rdy[0][3] = 1'b1;
      tick(1);
      valid     = '0;
      rdy[0][3] = 1'b0;
      rdy[1][3] = 1'b1;
      tick(1);
      rdy[1][3] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("t4_still_full", d, 3, 32'(of[d][3]), 32'h1);
         chk("t4_no_ovf",     d, 3, 32'(oo[d][3]), 32'h0);
         chk("t4_no_drop",    d, 3, get_cnt(d, 3), 32'd0);
         chk("t4_head",       d, 3, get_addr(d, 3), 32'd1);
      end
      rdy[0][3] = 1'b1;
      rdy[1][3] = 1'b1;
      tick(6);

      // All-lane burst with the consumer ready on alternate cycles.
      for (int k = 0; k < 4; k++) begin
         if (k < 3) begin
            for (int l = 0; l < INPUTS; l++) set_beat(l, l, 1'(k));
         end else begin
            valid = '0;
         end
         rdy[0] = (k % 2 == 0) ? '1 : '0;
         rdy[1] = rdy[0];
         tick(1);
      end
      rdy[0] = '1;
      rdy[1] = '1;
      tick(6);
      for (int d = 0; d < 2; d++) begin
         chk("t5_drained", d, 0, 32'(ov[d]), 32'h0);
         chk("t5_ovf_vec", d, 0, 32'(oo[d]), 32'h1);
         chk("t5_drop31",  d, 31, get_cnt(d, 31), 32'd0);
      end

      // Asynchronous reset while lane 2 holds three beats.
      rdy[0][2] = 1'b0;
      rdy[1][2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_beat(2, 40 + i, 1'b1);
         tick(1);
      end
      valid = '0;
      tick(2);
      chk("t6_held_p0", 0, 2, 32'(ov[0][2]), 32'h1);
      chk("t6_held_p1", 1, 2, 32'(ov[1][2]), 32'h1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("t6_async_valid", d, 2, 32'(ov[d]), 32'h0);
         chk("t6_async_full",  d, 2, 32'(of[d]), 32'h0);
         chk("t6_async_ovf",   d, 2, 32'(oo[d]), 32'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      tick(1);
      set_beat(2, 'h55, 1'b0);
      tick(1);
      valid = '0;
      chk("t6_post_p0", 0, 2, 32'(ov[0]), 32'h4);
      chk("t6_post_p1_early", 1, 2, 32'(ov[1]), 32'h0);
      tick(1);
      chk("t6_post_p1", 1, 2, 32'(ov[1]), 32'h4);
      chk("t6_post_addr", 1, 2, get_addr(1, 2), 32'h55);
      rdy[0] = '1;
      rdy[1] = '1;
      tick(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
